wb_scoreboard: RTL

// Register scoreboard and writeback arbiter for the pipelined core. Sits between decode (issue check),
// the single-cycle ALU/shift path and NUM_UNITS multi-cycle units (FPU, divider...).
// - Tracks pending destination registers of long-latency ops.
// - Stalls issue on RAW, WAW or busy-unit hazards.
// - Arbitrates the one regfile write port; ALU always wins, units round-robin.
// - Forwards the granted writeback data to the read operands.

---
 rtl/wb_scoreboard_pkg.sv | 21 ++
 rtl/wb_scoreboard_rr_arbiter.sv | 33 +++
 rtl/wb_scoreboard.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/wb_scoreboard_pkg.sv
// Shared widths, unit ids and writeback-source encoding for the writeback scoreboard.
package wb_scoreboard_pkg;

  localparam int unsigned UNIT_FPU = 0;
  localparam int unsigned UNIT_DIV = 1;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_UNIT = 2'd2
  } wb_src_e;

  function automatic int unsigned reg_aw(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned unit_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/wb_scoreboard_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr wins.
module wb_scoreboard_rr_arbiter
  import wb_scoreboard_pkg::*;
#(
  parameter  int unsigned N = 2,
  localparam int unsigned W = unit_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_any
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Register scoreboard and single-port writeback arbiter for long-latency units.
// ALU writeback has absolute priority; units share the port round-robin.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter  int unsigned DATA_W    = 16,
  parameter  int unsigned NUM_REGS  = 16,
  parameter  int unsigned NUM_UNITS = 2,
  localparam int unsigned REG_AW    = reg_aw(NUM_REGS),
  localparam int unsigned UNIT_W    = unit_w(NUM_UNITS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        iss_valid,
  input  logic                        iss_flush,
  input  logic [REG_AW-1:0]           iss_rs1,
  input  logic [REG_AW-1:0]           iss_rs2,
  input  logic                        iss_rs1_use,
  input  logic                        iss_rs2_use,
  input  logic [REG_AW-1:0]           iss_rd,
  input  logic                        iss_wr,
  input  logic                        iss_long,
  input  logic [UNIT_W-1:0]           iss_unit,
  output logic                        stall,
  output logic                        iss_fire,
  output logic [NUM_UNITS-1:0]        unit_start,
  input  logic                        alu_wr_en,
  input  logic [REG_AW-1:0]           alu_wr_addr,
  input  logic [DATA_W-1:0]           alu_wr_data,
  input  logic [NUM_UNITS-1:0]        cmp_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] cmp_data,
  output logic [NUM_UNITS-1:0]        cmp_ready,
  output logic                        wb_en,
  output logic [REG_AW-1:0]           wb_addr,
  output logic [DATA_W-1:0]           wb_data,
  output logic                        fwd1,
  output logic                        fwd2,
  output logic [NUM_UNITS-1:0]        busy_units
);

  logic [NUM_REGS-1:0]  pending;
  logic [NUM_UNITS-1:0] inflight;
  logic [NUM_UNITS-1:0] unit_wr;
  logic [REG_AW-1:0]    unit_rd [NUM_UNITS];
  logic [UNIT_W-1:0]    rr_ptr;

  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] grant;
  logic [UNIT_W-1:0]    grant_idx;
  logic                 grant_any;
  wb_src_e              wb_src;
  logic                 unit_ok;
  logic                 raw1, raw2, waw, busy_hit, hazard;

  // Completions without a matching in-flight op are ignored; the ALU blocks all grants.
  assign req = (reset || alu_wr_en) ? '0 : (cmp_valid & inflight);

  wb_scoreboard_rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign cmp_ready = grant;

  always_comb begin
    wb_src = WB_NONE;
    if (!reset) begin
      if (alu_wr_en)      wb_src = WB_ALU;
      else if (grant_any) wb_src = WB_UNIT;
    end
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    case (wb_src)
      WB_ALU: begin
        wb_en   = 1'b1;
        wb_addr = alu_wr_addr;
        wb_data = alu_wr_data;
      end
      WB_UNIT: begin
        wb_en   = unit_wr[grant_idx];
        wb_addr = unit_rd[grant_idx];
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
          if (grant[u]) wb_data = cmp_data[u*DATA_W +: DATA_W];
        end
      end
      default: ;
    endcase
  end

  // A hazard resolved by this cycle's writeback does not stall: the operand is forwarded.
  assign fwd1     = iss_rs1_use && wb_en && (wb_addr == iss_rs1);
  assign fwd2     = iss_rs2_use && wb_en && (wb_addr == iss_rs2);
  assign unit_ok  = 32'(iss_unit) < NUM_UNITS;
  assign raw1     = iss_rs1_use && pending[iss_rs1] && !fwd1;
  assign raw2     = iss_rs2_use && pending[iss_rs2] && !fwd2;
  assign waw      = iss_wr && pending[iss_rd] && !(wb_en && (wb_addr == iss_rd));
  assign busy_hit = iss_long && unit_ok && inflight[iss_unit] && !cmp_ready[iss_unit];
  assign hazard   = raw1 || raw2 || waw || busy_hit;

  assign stall      = !reset && iss_valid && !iss_flush && hazard;
  assign iss_fire   = !reset && iss_valid && !iss_flush && !hazard;
  assign busy_units = reset ? '0 : inflight;

  always_comb begin
    unit_start = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (iss_fire && iss_long && (iss_unit == UNIT_W'(u))) unit_start[u] = 1'b1;
    end
  end

  // Retire first, then issue, so a same-cycle issue to the same register keeps it pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      inflight <= '0;
      unit_wr  <= '0;
      rr_ptr   <= '0;
      for (int unsigned u = 0; u < NUM_UNITS; u++) unit_rd[u] <= '0;
    end else begin
      if (wb_src == WB_UNIT) begin
        inflight[grant_idx] <= 1'b0;
        if (unit_wr[grant_idx]) pending[unit_rd[grant_idx]] <= 1'b0;
        rr_ptr <= (grant_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : grant_idx + UNIT_W'(1);
      end
      if (iss_fire && iss_long && unit_ok) begin
        inflight[iss_unit] <= 1'b1;
        unit_rd[iss_unit]  <= iss_rd;
        unit_wr[iss_unit]  <= iss_wr;
        if (iss_wr) pending[iss_rd] <= 1'b1;
      end
    end
  end

endmodule
